pipe_run_ctrl: RTL

Pipeline run controller for the five-stage RISC-V core. It sits between `RISC_top` and the data path. After reset it holds the decode-stall and branch-select paths quiet for a parametrised number of cycles, then passes the hazard-unit signals through. It also provides halt-with-drain, single-step and a cycle-limited run mode, all driven by registered state rather than simulator forces.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/pipe_run_ctrl_sat_counter.sv | 26 ++
 rtl/pipe_run_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the pipeline run controller: run-state encoding and width.
package riscv_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_HALTED    = 3'd3,
    ST_STEP_IDLE = 3'd4,
    ST_STEP_ONE  = 3'd5,
    ST_DONE      = 3'd6
  } run_state_t;

  // States in which the whole pipeline advances and the hazard signals pass through.
  function automatic logic is_active(input run_state_t s);
    return (s == ST_RUN) || (s == ST_STEP_ONE);
  endfunction

endpackage

// File: rtl/pipe_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear, used for cycle and performance counts.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pipe_run_ctrl.sv
// Pipeline run controller: init hold-off, halt-with-drain, single-step and cycle-limited run.
// Optional stall/flush performance counters are built when PIPE_RUN_CTRL_PERF_EN is defined.
//
// state      | meaning
// INIT       | pipeline enabled, hazard outputs forced 0 for INIT_CYCLES
// RUN        | hazard signals pass through, all stages enabled
// DRAIN      | fetch frozen, older stages empty out for NUM_STAGES-1 cycles
// HALTED     | all stages frozen until halt_req drops
// STEP_IDLE  | frozen, waiting for a step_req rising edge
// STEP_ONE   | one cycle with RUN behaviour
// DONE       | run limit reached, frozen until reset
module pipe_run_ctrl
  import riscv_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int INIT_CYCLES = 3,
  parameter int MAX_CYCLES  = 35,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_in,
  input  logic                  pcsrc_in,
  input  logic                  halt_req,
  input  logic                  step_mode,
  input  logic                  step_req,
  output logic                  stall_out,
  output logic                  pcsrc_out,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] flush_mask,
  output logic [STATE_W-1:0]    state,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic                  done,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int SEQ_MAX = (INIT_CYCLES > NUM_STAGES) ? INIT_CYCLES : NUM_STAGES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam logic [SEQ_W-1:0] INIT_LAST  = SEQ_W'(INIT_CYCLES - 1);
  localparam logic [SEQ_W-1:0] DRAIN_LAST = SEQ_W'(NUM_STAGES - 2);
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_CYCLES - 1);

  run_state_t        r_state;
  logic              r_live;
  logic [SEQ_W-1:0]  r_seq;
  logic              r_step_prev;
  logic              r_step_edge;
  logic [CNT_W-1:0]  w_cycle_cnt;
  logic              w_active;

  // r_live keeps reset-value outputs until the first clock after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_INIT;
      r_live      <= 1'b0;
      r_seq       <= '0;
      r_step_prev <= 1'b0;
      r_step_edge <= 1'b0;
    end else begin
      r_live      <= 1'b1;
      r_step_prev <= step_req;
      // Edges arriving while a step is executing are dropped, not queued.
      r_step_edge <= step_req & ~r_step_prev & (r_state != ST_STEP_ONE);
      case (r_state)
        ST_INIT: begin
          if (r_live) begin
            if (r_seq == INIT_LAST) begin
              r_state <= ST_RUN;
              r_seq   <= '0;
            end else begin
              r_seq <= r_seq + SEQ_W'(1);
            end
          end
        end
        ST_RUN: begin
          if ((MAX_CYCLES != 0) && (w_cycle_cnt == MAX_LAST)) begin
            r_state <= ST_DONE;
          end else if (halt_req) begin
            r_state <= ST_DRAIN;
            r_seq   <= '0;
          end else if (step_mode) begin
            r_state <= ST_STEP_IDLE;
          end
        end
        ST_DRAIN: begin
          if (r_seq == DRAIN_LAST) begin
            r_state <= ST_HALTED;
            r_seq   <= '0;
          end else begin
            r_seq <= r_seq + SEQ_W'(1);
          end
        end
        ST_HALTED: begin
          if (!halt_req) r_state <= ST_RUN;
        end
        ST_STEP_IDLE: begin
          if (halt_req)         r_state <= ST_HALTED;
          else if (!step_mode)  r_state <= ST_RUN;
          else if (r_step_edge) r_state <= ST_STEP_ONE;
        end
        ST_STEP_ONE: r_state <= ST_STEP_IDLE;
        ST_DONE:     r_state <= ST_DONE;
        default:     r_state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    stage_en   = '0;
    flush_mask = '0;
    stall_out  = 1'b0;
    pcsrc_out  = 1'b0;
    if (!r_live) begin
      flush_mask = '1;
    end else begin
      case (r_state)
        ST_INIT: stage_en = '1;
        ST_RUN, ST_STEP_ONE: begin
          stage_en  = '1;
          stall_out = stall_in;
          pcsrc_out = pcsrc_in;
        end
        ST_DRAIN: begin
          stage_en  = {{(NUM_STAGES-1){1'b1}}, 1'b0};
          stall_out = stall_in;
        end
        default: ;
      endcase
    end
  end

  assign w_active  = is_active(r_state);
  assign state     = r_state;
  assign done      = (r_state == ST_DONE);
  assign cycle_cnt = w_cycle_cnt;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_active),
    .clr (1'b0),
    .cnt (w_cycle_cnt)
  );

`ifdef PIPE_RUN_CTRL_PERF_EN
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .en  (w_active & stall_in),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .en  (pcsrc_out),
    .clr (1'b0),
    .cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
